tu56_fe_arb: RTL and testbench

- Shares the single front-end (FE) host Avalon slave port among up to N TU56 drive units.
- Each unit raises read/write service requests on its fe_rq lines. The arbiter grants one unit at a time in round-robin order, interrupts the host, and routes host data accesses to the granted unit.
- Host switch-register accesses go to any unit chosen through a select register.
- Sits between the FE bridge and the bank of tu56 instances.

---
 rtl/tu56_fe_arb.sv | 205 ++++++++++++++++++++
 tb/tb_tu56_fe_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tu56_fe_arb.sv
// tu56_fe_arb: shares the front-end host slave port among N TU56 drive units.
// Units are granted one at a time in round-robin order. Host data accesses go
// to the granted unit, and switch-register accesses go to the unit in the
// select register.
module tu56_fe_arb #(
  parameter int N       = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        h_address,
  input  logic              h_read,
  input  logic              h_write,
  input  logic [31:0]       h_writedata,
  output logic [31:0]       h_readdata,
  output logic              h_irq,
  input  logic [4*N-1:0]    u_rq,
  output logic              u_address,
  output logic [N-1:0]      u_read,
  output logic [N-1:0]      u_write,
  output logic [31:0]       u_writedata,
  input  logic [32*N-1:0]   u_readdata
);

  localparam int UW = 3;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [UW-1:0]   gnt_r, gnt_s;
  logic [UW-1:0]   last_r, last_s;
  logic [UW-1:0]   sel_r, sel_s;
  logic            ovr_r, ovr_s;
  logic            irq_r, irq_s;
  logic [CW-1:0]   cnt_r, cnt_s;

  logic [N-1:0]    pend_s;
  logic [3:0]      rq_arr_s [N];
  logic [31:0]     rd_arr_s [N];
  logic            found_s;
  logic [UW-1:0]   found_idx_s;
  logic            set_ovr_s;
  logic            clr_ovr_s;
  logic [31:0]     status_s;

  // Unpack the flat per-unit buses and derive each unit's service-pending bit.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rq_arr_s[i] = u_rq[4*i +: 4];
      rd_arr_s[i] = u_readdata[32*i +: 32];
      pend_s[i]   = u_rq[4*i+2] | u_rq[4*i+3];
    end
  end

  // Round-robin search: find the first pending unit after the last one served.
  always_comb begin
    int            idx_v;
    logic [UW-1:0] cand_v;
    idx_v       = 0;
    cand_v      = '0;
    found_s     = 1'b0;
    found_idx_s = '0;
    for (int k = 1; k <= N; k++) begin
      idx_v  = (int'(last_r) + k) % N;
      cand_v = UW'(idx_v);
      if (!found_s && pend_s[cand_v]) begin
        found_s     = 1'b1;
        found_idx_s = cand_v;
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Status word: valid, granted unit, its live request bits, sticky overrun.
  always_comb begin
    status_s = {23'd0, ovr_r, rq_arr_s[gnt_r], gnt_r, (state_r == GRANT)};
  end

  // Next-state and next-register values for the grant FSM and host registers.
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    last_s    = last_r;
    irq_s     = irq_r;
    cnt_s     = cnt_r;
    sel_s     = sel_r;
    set_ovr_s = 1'b0;
    clr_ovr_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = GRANT;
          gnt_s   = found_idx_s;
          irq_s   = 1'b1;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (!pend_s[gnt_r]) begin
          state_s = IDLE;
          last_s  = gnt_r;
          irq_s   = 1'b0;
        end else if (cnt_r != CW'(TIMEOUT)) begin
          // Overrun fires once, on the cycle the counter reaches TIMEOUT, so a
          // host clear after saturation sticks while the grant is still held.
          cnt_s     = cnt_r + CW'(1);
          set_ovr_s = (cnt_r == CW'(TIMEOUT - 1));
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (h_write && (h_address == 2'd3) && (int'(h_writedata[2:0]) < N)) begin
      sel_s = h_writedata[UW-1:0];
    end else begin
      sel_s = sel_r;
    end

    if (h_write && (h_address == 2'd2) && h_writedata[8]) begin
      clr_ovr_s = 1'b1;
    end else begin
      clr_ovr_s = 1'b0;
    end

    if (set_ovr_s) begin
      ovr_s = 1'b1;
    end else if (clr_ovr_s) begin
      ovr_s = 1'b0;
    end else begin
      ovr_s = ovr_r;
    end
  end

  // State and register update; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      last_r  <= UW'(N - 1);
      sel_r   <= '0;
      ovr_r   <= 1'b0;
      irq_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      last_r  <= last_s;
      sel_r   <= sel_s;
      ovr_r   <= ovr_s;
      irq_r   <= irq_s;
      cnt_r   <= cnt_s;
    end
  end

  // Host access routing: strobes to one unit at most, plus the read-data mux.
  always_comb begin
    u_address  = 1'b0;
    u_read     = '0;
    u_write    = '0;
    h_readdata = 32'd0;
    case (h_address)
      2'd0: begin
        if (state_r == GRANT) begin
          // A unit is never strobed while reset is asserted.
          u_read[gnt_r]  = h_read & reset_n;
          u_write[gnt_r] = h_write & reset_n;
          h_readdata     = rd_arr_s[gnt_r];
        end else begin
          h_readdata = 32'd0;
        end
      end
      2'd1: begin
        u_address      = 1'b1;
        u_read[sel_r]  = h_read & reset_n;
        u_write[sel_r] = h_write & reset_n;
        h_readdata     = rd_arr_s[sel_r];
      end
      2'd2: begin
        h_readdata = status_s;
      end
      2'd3: begin
        h_readdata = {29'd0, sel_r};
      end
      default: begin
        h_readdata = 32'd0;
      end
    endcase
  end

  assign h_irq       = irq_r;
  assign u_writedata = h_writedata;

endmodule

// File: tb/tb_tu56_fe_arb.sv
// Directed self-checking bench for tu56_fe_arb (N=8).
module tb_tu56_fe_arb;

  localparam int N       = 8;
  localparam int TIMEOUT = 4096;

  logic              clk;
  logic              reset_n;
  logic [1:0]        h_address;
  logic              h_read;
  logic              h_write;
  logic [31:0]       h_writedata;
  logic [31:0]       h_readdata;
  logic              h_irq;
  logic [4*N-1:0]    u_rq;
  logic              u_address;
  logic [N-1:0]      u_read;
  logic [N-1:0]      u_write;
  logic [31:0]       u_writedata;
  logic [32*N-1:0]   u_readdata;

  int n_tests;
  int n_fail;

  tu56_fe_arb #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .h_address   (h_address),
    .h_read      (h_read),
    .h_write     (h_write),
    .h_writedata (h_writedata),
    .h_readdata  (h_readdata),
    .h_irq       (h_irq),
    .u_rq        (u_rq),
    .u_address   (u_address),
    .u_read      (u_read),
    .u_write     (u_write),
    .u_writedata (u_writedata),
    .u_readdata  (u_readdata)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 2 ns past it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Combinational register read between edges.
  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    h_address = a;
    h_read    = 1'b1;
    #1;
    check(tag, h_readdata, exp);
    h_read = 1'b0;
    #1;
  endtask

  // Register write that takes effect at the next edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    h_address   = a;
    h_writedata = d;
    h_write     = 1'b1;
    tick();
    h_write = 1'b0;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    h_address   = 2'd0;
    h_read      = 1'b0;
    h_write     = 1'b0;
    h_writedata = 32'd0;
    u_rq        = '0;
    for (int i = 0; i < N; i++) u_readdata[32*i +: 32] = 32'h100 + i;
    u_readdata[63:32] = 32'h13;
    tick();
    tick();
    reset_n = 1'b1;
    #1;

    // Reset state
    check("rst_irq", {31'd0, h_irq}, 32'd0);
    chk_rd("rst_status", 2'd2, 32'h0);
    chk_rd("rst_sel", 2'd3, 32'h0);

    // Round-robin: units 0, 3, 5 hold rd_rq
    u_rq[2] = 1'b1; u_rq[14] = 1'b1; u_rq[22] = 1'b1;
    tick();
    check("rr_irq0", {31'd0, h_irq}, 32'd1);
    chk_rd("rr_g0", 2'd2, 32'h41);
    h_address = 2'd0; h_read = 1'b1; #1;
    check("rr_rd0_strobe", {24'd0, u_read}, 32'h01);
    h_read = 1'b0;
    u_rq[2] = 1'b0;
    tick();
    check("rr_rel_irq", {31'd0, h_irq}, 32'd0);
    u_rq[2] = 1'b1;
    tick();
    chk_rd("rr_g3", 2'd2, 32'h47);
    u_rq[14] = 1'b0;
    tick();
    check("rr_rel3_irq", {31'd0, h_irq}, 32'd0);
    tick();
    chk_rd("rr_g5", 2'd2, 32'h4B);
    u_rq[22] = 1'b0;
    tick();
    tick();
    chk_rd("rr_g0_again", 2'd2, 32'h41);
    u_rq[2] = 1'b0;
    tick();
    check("rr_idle_irq", {31'd0, h_irq}, 32'd0);

    // Single request: unit 2 wr_rq
    u_rq[11] = 1'b1;
    #1;
    check("sr_irq_pre", {31'd0, h_irq}, 32'd0);
    tick();
    check("sr_irq", {31'd0, h_irq}, 32'd1);
    chk_rd("sr_status", 2'd2, 32'h85);
    h_address = 2'd0; h_writedata = 32'h5; h_write = 1'b1; #1;
    check("sr_u_write", {24'd0, u_write}, 32'h04);
    check("sr_u_read", {24'd0, u_read}, 32'h00);
    check("sr_u_addr", {31'd0, u_address}, 32'd0);
    check("sr_wdata", u_writedata, 32'h5);
    tick();
    h_write = 1'b0; #1;
    check("sr_u_write_off", {24'd0, u_write}, 32'h00);
    u_rq[11] = 1'b0;
    #1;
    check("sr_irq_hold", {31'd0, h_irq}, 32'd1);
    tick();
    check("sr_irq_rel", {31'd0, h_irq}, 32'd0);
    chk_rd("sr_status_idle", 2'd2, 32'h4);

    // Read path: unit 1 rd_rq
    u_rq[6] = 1'b1;
    tick();
    chk_rd("rp_status", 2'd2, 32'h43);
    h_address = 2'd0; h_read = 1'b1; #1;
    check("rp_data", h_readdata, 32'h13);
    check("rp_u_read", {24'd0, u_read}, 32'h02);
    h_read = 1'b0;
    u_rq[6] = 1'b0;
    tick();

    // No grant: data register inert, switch register via select
    h_address = 2'd0; h_read = 1'b1; #1;
    check("ng_u_read", {24'd0, u_read}, 32'h00);
    check("ng_rdata", h_readdata, 32'h0);
    h_read = 1'b0; h_write = 1'b1; h_writedata = 32'hFFFF_FFFF; #1;
    check("ng_u_write", {24'd0, u_write}, 32'h00);
    h_write = 1'b0;
    wr(2'd3, 32'd6);
    chk_rd("ng_sel", 2'd3, 32'd6);
    h_address = 2'd1; h_read = 1'b1; #1;
    check("sw_u_read", {24'd0, u_read}, 32'h40);
    check("sw_u_addr", {31'd0, u_address}, 32'd1);
    check("sw_rdata", h_readdata, 32'h106);
    h_read = 1'b0;

    // Timeout: unit 4 granted and left unanswered
    u_rq[18] = 1'b1;
    tick();
    chk_rd("to_status", 2'd2, 32'h49);
    repeat (TIMEOUT - 1) tick();
    chk_rd("to_not_yet", 2'd2, 32'h49);
    tick();
    chk_rd("to_overrun", 2'd2, 32'h149);
    check("to_irq_held", {31'd0, h_irq}, 32'd1);
    repeat (5) tick();
    wr(2'd2, 32'h100);
    chk_rd("to_cleared", 2'd2, 32'h49);
    u_rq[18] = 1'b0;
    tick();

    // Reset mid-grant: unit 7 wr_rq
    wr(2'd3, 32'd3);
    u_rq[31] = 1'b1;
    tick();
    chk_rd("rm_status", 2'd2, 32'h8F);
    reset_n = 1'b0;
    h_address = 2'd0; h_write = 1'b1; #1;
    check("rm_no_strobe", {24'd0, u_write}, 32'h00);
    tick();
    h_write = 1'b0;
    reset_n = 1'b1;
    #1;
    check("rm_irq", {31'd0, h_irq}, 32'd0);
    chk_rd("rm_status0", 2'd2, 32'h0);
    chk_rd("rm_sel0", 2'd3, 32'h0);
    tick();
    check("rm_regrant_irq", {31'd0, h_irq}, 32'd1);
    chk_rd("rm_regrant", 2'd2, 32'h8F);
    u_rq[31] = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
